adc_serial_capture: RTL

ADC_SERIAL_CAPTURE -- requirements
Module: adc_serial_capture

---
 rtl/adc_capture_pkg.sv | 18 +
 rtl/adc_sclk_gen.sv | 52 +++++
 rtl/adc_serial_capture.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// Shared types for the serial ADC capture block: FSM state encoding and frame sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CS_SETUP = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_QUIET    = 2'd3
    } state_e;

    // Total serial bits clocked out of the ADC per conversion.
    function automatic int frame_bits(input int lead_bits, input int data_w);
        return lead_bits + data_w;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial-clock divider: CLK_DIV-cycle sclk period, low phase first, idle high when not running.
// Latency: low_end_o/period_end_o are combinational from the phase counter; counter restarts at 0 on run_i.
// Backpressure: none; runs freely while run_i is high.
//
// Ports:
//   clk_i        - core clock, rising edge
//   reset_i      - synchronous active-low reset
//   run_i        - enable; counter held at 0 while low
//   sclk_o       - divided serial clock (1 while idle)
//   low_end_o    - strobe on the clk edge that ends the sclk low phase
//   period_end_o - strobe on the clk edge that ends the full sclk period
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic run_i,
    output logic sclk_o,
    output logic low_end_o,
    output logic period_end_o
);

    localparam int HALF  = CLK_DIV / 2;
    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // First half of every period is the low phase.
    assign sclk_o       = !(run_i && (cnt_q < CNT_W'(HALF)));
    assign low_end_o    = run_i && (cnt_q == CNT_W'(HALF - 1));
    assign period_end_o = run_i && (cnt_q == CNT_W'(CLK_DIV - 1));

endmodule

// File: rtl/adc_serial_capture.sv
// Serial ADC frame capture: drives cs_n/sclk, shifts in LEAD_BITS+DATA_W bits MSB first, presents DATA_W sample.
// Latency: sample/sample_valid appear the cycle after the clk edge that ends the last sclk period.
// Backpressure: valid/ready hold; a frame completing while a sample is held and not accepted is dropped (overrun).
//
// Ports:
//   clk, reset (sync, active-low), en (level enable for back-to-back frames)
//   adc_sdata in; adc_cs_n, adc_sclk out to the converter
//   sample/sample_valid out, sample_ready in; overrun, lead_err sticky flags
// Build option: define ADC_CAPTURE_LEAD_CHECK_EN to reject frames whose leading bits are not all zero
// (sets lead_err); without it leading bits are ignored and lead_err is tied to 0.
module adc_serial_capture
    import adc_capture_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 4,
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              adc_sdata,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              lead_err
);

    localparam int FRAME_BITS = frame_bits(LEAD_BITS, DATA_W);
    localparam int HALF       = CLK_DIV / 2;
    localparam int TMR_MAX    = (HALF > QUIET_CYC) ? HALF : QUIET_CYC;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);
    localparam int BIT_W      = $clog2(FRAME_BITS);
`ifdef ADC_CAPTURE_LEAD_CHECK_EN
    // Keep the leading bits so they can be inspected at frame end.
    localparam int SHR_W      = FRAME_BITS;
`else
    // Only the last DATA_W bits matter; older bits fall off the top.
    localparam int SHR_W      = DATA_W;
`endif

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [SHR_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               frame_done;
    logic               lead_bad;
    logic               sclk_run, low_end, period_end;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i        (clk),
        .reset_i      (reset),
        .run_i        (sclk_run),
        .sclk_o       (adc_sclk),
        .low_end_o    (low_end),
        .period_end_o (period_end)
    );

    assign sclk_run = (state_q == ST_SHIFT);
    assign adc_cs_n = (state_q == ST_IDLE) || (state_q == ST_QUIET);

    // ------------------------------------------------------------------
    // Frame sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_CS_SETUP;
                    tmr_d   = '0;
                end
            end
            ST_CS_SETUP: begin
                if (tmr_q == TMR_W'(HALF - 1)) begin
                    state_d = ST_SHIFT;
                    tmr_d   = '0;
                    bit_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (low_end) begin
                    shift_d = {shift_q[SHR_W-2:0], adc_sdata};
                end
                // The last bit was captured at this period's low_end, so the
                // shift register is complete when its period ends.
                if (period_end) begin
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d    = ST_QUIET;
                        tmr_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_QUIET: begin
                if (tmr_q == TMR_W'(QUIET_CYC - 1)) begin
                    state_d = en ? ST_CS_SETUP : ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Leading-bit check
    // ------------------------------------------------------------------
`ifdef ADC_CAPTURE_LEAD_CHECK_EN
    logic lead_err_q;

    assign lead_bad = |shift_q[FRAME_BITS-1:DATA_W];
    assign lead_err = lead_err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lead_err_q <= 1'b0;
        end else if (frame_done && lead_bad) begin
            lead_err_q <= 1'b1;
        end
    end
`else
    assign lead_bad = 1'b0;
    assign lead_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output holding register with valid/ready handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        // A completing frame may reuse the slot freed by a same-cycle accept.
        if (frame_done && !lead_bad) begin
            if (!valid_q || sample_ready) begin
                sample_d = shift_q[DATA_W-1:0];
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule
